// File: rtl/rc_settle_monitor.sv
`default_nettype none
// ============================================================================
// rc_settle_monitor : settle-time and fast/slow discrepancy checker for RC models
// Revision 1.0 : initial release
// ============================================================================
module rc_settle_monitor #(
  parameter int WIDTH       = 16,
  parameter int FRAC        = 8,
  parameter int TOL         = 4,
  parameter int MAX_DIFF    = 1,
  parameter int HOLD        = 8,
  parameter int MAX_SAMPLES = 4096,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sample_en_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] v_a_i,
  input  logic [WIDTH-1:0] v_b_i,
  input  logic [WIDTH-1:0] target_i,
  output logic             busy_o,
  output logic             settled_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] settle_cycles_o,
  output logic [WIDTH-1:0] max_abs_diff_o,
  output logic [CNT_W-1:0] mismatch_cnt_o
);

  localparam int IDX_W = $clog2(MAX_SAMPLES + 1);
  localparam int RUN_W = $clog2(HOLD + 1);

  localparam logic [WIDTH:0]   ABS_SAT    = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] TOL_V      = WIDTH'(TOL);
  localparam logic [WIDTH-1:0] MAX_DIFF_V = WIDTH'(MAX_DIFF);
  localparam logic [RUN_W-1:0] HOLD_V     = RUN_W'(HOLD);
  localparam logic [IDX_W-1:0] MAX_SMP_V  = IDX_W'(MAX_SAMPLES);

  if ((FRAC >= WIDTH) || (HOLD < 1) || (MAX_SAMPLES < HOLD)) begin : g_param_check
    $error("rc_settle_monitor: invalid FRAC/HOLD/MAX_SAMPLES configuration");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRACK   = 2'd1,
    S_SETTLED = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [RUN_W-1:0] run_len_q;
  logic [WIDTH-1:0] target_q;
  logic             busy_q;
  logic             settled_q;
  logic             timeout_q;
  logic [CNT_W-1:0] settle_cycles_q;
  logic [WIDTH-1:0] max_abs_diff_q;
  logic [CNT_W-1:0] mismatch_cnt_q;

  // Magnitude of a WIDTH+1 difference, clipped to the largest positive WIDTH value.
  function automatic logic [WIDTH-1:0] sat_abs(input logic [WIDTH:0] d);
    logic [WIDTH:0] mag;
    mag = d[WIDTH] ? (~d + 1'b1) : d;
    if (mag > ABS_SAT) begin
      mag = ABS_SAT;
    end
    return mag[WIDTH-1:0];
  endfunction

  logic [WIDTH:0]   diff_t;
  logic [WIDTH:0]   diff_ab;
  logic [WIDTH-1:0] abs_t;
  logic [WIDTH-1:0] abs_ab;
  logic             in_band;
  logic [RUN_W-1:0] run_len_d;
  logic [IDX_W-1:0] idx_d;
  logic             hold_hit;
  logic             last_sample;

  always_comb begin
    diff_t      = {v_a_i[WIDTH-1], v_a_i} - {target_q[WIDTH-1], target_q};
    diff_ab     = {v_a_i[WIDTH-1], v_a_i} - {v_b_i[WIDTH-1], v_b_i};
    abs_t       = sat_abs(diff_t);
    abs_ab      = sat_abs(diff_ab);
    in_band     = (abs_t <= TOL_V);
    run_len_d   = in_band ? (run_len_q + 1'b1) : '0;
    idx_d       = idx_q + 1'b1;
    hold_hit    = in_band && (run_len_d == HOLD_V);
    last_sample = (idx_d == MAX_SMP_V);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      run_len_q       <= '0;
      target_q        <= '0;
      busy_q          <= 1'b0;
      settled_q       <= 1'b0;
      timeout_q       <= 1'b0;
      settle_cycles_q <= '0;
      max_abs_diff_q  <= '0;
      mismatch_cnt_q  <= '0;
    end else if (start_i) begin
      // A restart wins over any sample strobe arriving in the same cycle.
      state_q         <= S_TRACK;
      idx_q           <= '0;
      run_len_q       <= '0;
      target_q        <= target_i;
      busy_q          <= 1'b1;
      settled_q       <= 1'b0;
      timeout_q       <= 1'b0;
      settle_cycles_q <= '0;
      max_abs_diff_q  <= '0;
      mismatch_cnt_q  <= '0;
    end else if ((state_q == S_TRACK) && sample_en_i) begin
      if (in_band && (run_len_q == '0)) begin
        settle_cycles_q <= CNT_W'(idx_q);
      end
      run_len_q <= run_len_d;
      idx_q     <= idx_d;
      if (abs_ab > max_abs_diff_q) begin
        max_abs_diff_q <= abs_ab;
      end
      if ((abs_ab > MAX_DIFF_V) && (mismatch_cnt_q != '1)) begin
        mismatch_cnt_q <= mismatch_cnt_q + 1'b1;
      end
      // Settling on the final allowed sample counts as settled, not timed out.
      if (hold_hit) begin
        state_q   <= S_SETTLED;
        busy_q    <= 1'b0;
        settled_q <= 1'b1;
      end else if (last_sample) begin
        state_q   <= S_TIMEOUT;
        busy_q    <= 1'b0;
        timeout_q <= 1'b1;
      end
    end
  end

  assign busy_o          = busy_q;
  assign settled_o       = settled_q;
  assign timeout_o       = timeout_q;
  assign settle_cycles_o = settle_cycles_q;
  assign max_abs_diff_o  = max_abs_diff_q;
  assign mismatch_cnt_o  = mismatch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rc_settle_monitor.sv
`default_nettype none
// ============================================================================
// tb_rc_settle_monitor : directed scoreboard bench for rc_settle_monitor
// Revision 1.0 : initial release
// ============================================================================
module tb_rc_settle_monitor;

  localparam int WIDTH = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             sample_en;
  logic             start;
  logic [WIDTH-1:0] v_a;
  logic [WIDTH-1:0] v_b;
  logic [WIDTH-1:0] target;
  logic             busy;
  logic             settled;
  logic             timeout;
  logic [CNT_W-1:0] settle_cycles;
  logic [WIDTH-1:0] max_abs_diff;
  logic [CNT_W-1:0] mismatch_cnt;

  always #5 clk = ~clk;

  rc_settle_monitor #(
    .WIDTH(16), .FRAC(8), .TOL(4), .MAX_DIFF(1),
    .HOLD(8), .MAX_SAMPLES(16), .CNT_W(16)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .sample_en_i    (sample_en),
    .start_i        (start),
    .v_a_i          (v_a),
    .v_b_i          (v_b),
    .target_i       (target),
    .busy_o         (busy),
    .settled_o      (settled),
    .timeout_o      (timeout),
    .settle_cycles_o(settle_cycles),
    .max_abs_diff_o (max_abs_diff),
    .mismatch_cnt_o (mismatch_cnt)
  );

  typedef struct packed {
    logic        settled;
    logic        timeout;
    logic [15:0] sc;
    logic [15:0] maxd;
    logic [15:0] mm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  // Result monitor: a completed measurement is presented when settled/timeout rises.
  logic prev_done = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if ((settled | timeout) && !prev_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_settled", 32'(settled), 32'(mon_e.settled));
        check("res_timeout", 32'(timeout), 32'(mon_e.timeout));
        check("res_settle_cycles", 32'(settle_cycles), 32'(mon_e.sc));
        check("res_max_abs_diff", 32'(max_abs_diff), 32'(mon_e.maxd));
        check("res_mismatch_cnt", 32'(mismatch_cnt), 32'(mon_e.mm));
      end
    end
    prev_done = settled | timeout;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end at a falling edge.
  task automatic start_meas(input logic [15:0] t);
    start  = 1'b1;
    target = t;
    @(negedge clk);
    start  = 1'b0;
    target = 16'($urandom);
  endtask

  task automatic samp(input logic [15:0] a, input logic [15:0] b);
    sample_en = 1'b1;
    v_a       = a;
    v_b       = b;
    @(negedge clk);
    sample_en = 1'b0;
    v_a       = 16'($urandom);
    v_b       = 16'($urandom);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("result_presented", 32'(exp_q.size() == 0), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_settled"}, 32'(settled), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_settle_cycles"}, 32'(settle_cycles), 32'd0);
    check({tag, "_max_abs_diff"}, 32'(max_abs_diff), 32'd0);
    check({tag, "_mismatch_cnt"}, 32'(mismatch_cnt), 32'd0);
  endtask

  logic [15:0] diffs[8] = '{16'd0, 16'd1, 16'd2, -16'sd3, 16'd1, 16'd0, 16'd0, 16'd0};

  initial begin
    rst_ni = 1'b0; sample_en = 1'b0; start = 1'b0;
    v_a = '0; v_b = '0; target = '0;

    // 1: reset with random activity on the inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sample_en = 1'($urandom); start = 1'($urandom);
      v_a = 16'($urandom); v_b = 16'($urandom); target = 16'($urandom);
    end
    @(negedge clk);
    check_zero("reset");
    rst_ni = 1'b1; start = 1'b0; sample_en = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    samp(16'h0100, 16'h0000);
    check("idle_ignore_mismatch", 32'(mismatch_cnt), 32'd0);
    check("idle_ignore_busy", 32'(busy), 32'd0);

    // 2: ramp 0x00C0 +8/sample to 0x0100, then hold; settles on the 16th sample
    exp_q.push_back('{1'b1, 1'b0, 16'd8, 16'd0, 16'd0});
    start_meas(16'h0100);
    check("track_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      samp((i < 8) ? 16'(16'h00C0 + 8 * i) : 16'h0100, (i < 8) ? 16'(16'h00C0 + 8 * i) : 16'h0100);
    end
    wait_done();
    samp(16'h0000, 16'h7000);
    samp(16'h0000, 16'h7000);
    check("frozen_settled", 32'(settled), 32'd1);
    check("frozen_settle_cycles", 32'(settle_cycles), 32'd8);
    check("frozen_mismatch", 32'(mismatch_cnt), 32'd0);
    check("frozen_busy", 32'(busy), 32'd0);

    // 3: bounce - 5 in-band, glitch at target+10, 8 fresh in-band
    exp_q.push_back('{1'b1, 1'b0, 16'd6, 16'd0, 16'd0});
    start_meas(16'h0100);
    check("restart_clears_settled", 32'(settled), 32'd0);
    for (int i = 0; i < 5; i++) samp(16'h0101, 16'h0101);
    samp(16'h010A, 16'h010A);
    for (int i = 0; i < 7; i++) samp(16'h00FC, 16'h00FC);
    check("bounce_not_yet_settled", 32'(settled), 32'd0);
    check("bounce_still_busy", 32'(busy), 32'd1);
    samp(16'h0104, 16'h0104);
    wait_done();

    // 4: discrepancy pattern 0,1,2,-3,1 then clean
    exp_q.push_back('{1'b1, 1'b0, 16'd0, 16'd3, 16'd2});
    start_meas(16'h0100);
    for (int i = 0; i < 8; i++) samp(16'h0100, 16'(16'h0100 - diffs[i]));
    wait_done();

    // 5: extremes, never in band -> timeout after 16 samples
    exp_q.push_back('{1'b0, 1'b1, 16'd0, 16'h7FFF, 16'd16});
    start_meas(16'h8000);
    for (int i = 0; i < 15; i++) samp(16'h7FFF, 16'h8000);
    check("extreme_no_early_timeout", 32'(timeout), 32'd0);
    check("extreme_max_sat", 32'(max_abs_diff), 32'h7FFF);
    samp(16'h7FFF, 16'h8000);
    wait_done();

    // 6a: restart mid-TRACK with a sample strobe in the same cycle
    start_meas(16'h0100);
    for (int i = 0; i < 3; i++) samp(16'h0100, 16'h00F0);
    check("pre_restart_mismatch", 32'(mismatch_cnt), 32'd3);
    sample_en = 1'b1; v_a = 16'h0100; v_b = 16'h00F0;
    start_meas(16'h0100);
    sample_en = 1'b0;
    check("restart_mismatch_cleared", 32'(mismatch_cnt), 32'd0);
    check("restart_max_cleared", 32'(max_abs_diff), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    exp_q.push_back('{1'b1, 1'b0, 16'd0, 16'd0, 16'd0});
    for (int i = 0; i < 8; i++) samp(16'h0100, 16'h0100);
    wait_done();

    // 6b: asynchronous reset mid-TRACK, checked before the next rising edge
    start_meas(16'h0100);
    samp(16'h0100, 16'h00F0);
    samp(16'h0100, 16'h00F0);
    check("abort_pre_mismatch", 32'(mismatch_cnt), 32'd2);
    #3;
    rst_ni = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("post_abort_busy", 32'(busy), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
